// File: rtl/rmu_pkg.sv
// Shared types and defaults for the RMU serial receive controller.
package rmu_pkg;

  localparam int RMU_NBITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_HOLD   = 2'd3
  } rmu_state_e;

endpackage

// File: rtl/rmu_shift.sv
// Serial-in/parallel-out register; new bits enter at the LSB so an MSB-first stream lands in order.
module rmu_shift #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             din,
  output logic [NBITS-1:0] q
);

  logic [NBITS-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (shift_en) q_d = {q_q[NBITS-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rmu_rx_ctrl.sv
// RMU frame receiver: header strobe, NBITS serial data bits, optional odd parity,
// then the frame is held for a valid/ready consumer.
module rmu_rx_ctrl
  import rmu_pkg::*;
#(
  parameter int NBITS     = RMU_NBITS,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ale,
  input  logic             ps1,
  input  logic             rmuadd,
  input  logic             data_ready,
  output logic [NBITS-1:0] rmudata,
  output logic             data_valid,
  output logic             port_id,
  output logic             par_err,
  output logic             ovr,
  output logic             busy,
  output rmu_state_e       dbg_state
);

  localparam int CW = $clog2(NBITS) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

  // Handshake: a held frame retires on the rising edge where data_valid && data_ready;
  // data_valid never drops before that, and rmudata/port_id/par_err stay stable while it is high.
  rmu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] rmudata_q, rmudata_d;
  logic             valid_q, valid_d;
  logic             port_q, port_d;
  logic             par_err_q, par_err_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             shift_en;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] shift_next;

  rmu_shift #(.NBITS(NBITS)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (rmuadd),
    .q        (shift_q)
  );

  assign shift_next = {shift_q[NBITS-2:0], rmuadd};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rmudata_d = rmudata_q;
    valid_d   = valid_q;
    port_d    = port_q;
    par_err_d = par_err_q;
    ovr_d     = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ale) begin
          port_d  = ps1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        ovr_d    = ale;
        if (cnt_q == LAST_BIT) begin
          if (PARITY_EN) begin
            state_d = ST_PARITY;
          end else begin
            state_d   = ST_HOLD;
            valid_d   = 1'b1;
            rmudata_d = shift_next;
            par_err_d = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        ovr_d     = ale;
        state_d   = ST_HOLD;
        valid_d   = 1'b1;
        rmudata_d = shift_q;
        // Odd parity: an even count of ones across data and parity bit is an error.
        par_err_d = ~(^shift_q ^ rmuadd);
      end
      ST_HOLD: begin
        if (data_ready) begin
          valid_d = 1'b0;
          if (ale) begin
            port_d  = ps1;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ovr_d = ale;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rmudata_q <= '0;
      valid_q   <= 1'b0;
      port_q    <= 1'b0;
      par_err_q <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rmudata_q <= rmudata_d;
      valid_q   <= valid_d;
      port_q    <= port_d;
      par_err_q <= par_err_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign rmudata    = rmudata_q;
  assign data_valid = valid_q;
  assign port_id    = port_q;
  assign par_err    = par_err_q;
  assign ovr        = ovr_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rmu_rx_ctrl.sv
// Bench for rmu_rx_ctrl: directed frames plus randomized frames against a frame-level model.
module tb_rmu_rx_ctrl;
  import rmu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ale = 1'b0;
  logic ps1 = 1'b0;
  logic rmuadd = 1'b0;
  logic data_ready = 1'b0;

  logic [7:0] rmudata, np_rmudata;
  logic       data_valid, port_id, par_err, ovr, busy;
  logic       np_valid, np_port_id, np_par_err, np_ovr, np_busy;
  rmu_state_e dbg_state, np_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rmu_rx_ctrl #(.NBITS(8), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .ale(ale), .ps1(ps1), .rmuadd(rmuadd),
    .data_ready(data_ready), .rmudata(rmudata), .data_valid(data_valid),
    .port_id(port_id), .par_err(par_err), .ovr(ovr), .busy(busy),
    .dbg_state(dbg_state)
  );

  rmu_rx_ctrl #(.NBITS(8), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .reset(reset), .ale(ale), .ps1(ps1), .rmuadd(rmuadd),
    .data_ready(data_ready), .rmudata(np_rmudata), .data_valid(np_valid),
    .port_id(np_port_id), .par_err(np_par_err), .ovr(np_ovr), .busy(np_busy),
    .dbg_state(np_dbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Odd parity model: an error whenever data ones plus parity bit is an even count.
  function automatic logic model_par_err(input logic [7:0] d, input logic pb);
    int ones;
    ones = pb;
    for (int i = 0; i < 8; i++) ones += d[i];
    return (ones % 2) == 0;
  endfunction

  // Header cycle then the data bits MSB first, then the parity bit when requested.
  // Returns just after the edge on which the final bit was sampled.
  task automatic drive_frame(input logic p, input logic [7:0] d, input logic pb,
                             input bit with_par, output logic valid_early);
    valid_early = 1'b0;
    ale = 1'b1; ps1 = p;
    tick;
    ale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rmuadd = d[7-k];
      tick;
      if (k < 7 || with_par) valid_early |= (with_par ? data_valid : np_valid);
    end
    if (with_par) begin
      rmuadd = pb;
      tick;
    end
    rmuadd = 1'b0;
  endtask

  task automatic retire;
    data_ready = 1'b1;
    tick;
    data_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    n_checks++; if (rmudata !== 8'h00) $display("FAIL reset_rmudata: got %h want 00", rmudata); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid); else n_pass++;
    n_checks++; if (port_id !== 1'b0) $display("FAIL reset_port: got %b want 0", port_id); else n_pass++;
    n_checks++; if (par_err !== 1'b0) $display("FAIL reset_par_err: got %b want 0", par_err); else n_pass++;
    n_checks++; if (ovr !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ovr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_frame_a5(input logic pb);
    logic early;
    drive_frame(1'b1, 8'hA5, pb, 1'b1, early);
    n_checks++; if (early !== 1'b0) $display("FAIL a5_early_valid: got %b want 0", early); else n_pass++;
    n_checks++; if (data_valid !== 1'b1) $display("FAIL a5_valid: got %b want 1", data_valid); else n_pass++;
    n_checks++; if (rmudata !== 8'hA5) $display("FAIL a5_data: got %h want a5", rmudata); else n_pass++;
    n_checks++; if (port_id !== 1'b1) $display("FAIL a5_port: got %b want 1", port_id); else n_pass++;
    n_checks++; if (par_err !== model_par_err(8'hA5, pb))
      $display("FAIL a5_par_err: got %b want %b", par_err, model_par_err(8'hA5, pb)); else n_pass++;
    retire;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL a5_retire_valid: got %b want 0", data_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL a5_retire_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rmudata !== 8'hA5) $display("FAIL a5_keep_data: got %h want a5", rmudata); else n_pass++;
  endtask

  task automatic test_hold_stall;
    logic early;
    drive_frame(1'b0, 8'h5A, 1'b0, 1'b1, early);
    for (int i = 0; i < 5; i++) begin
      ale = (i == 2); ps1 = 1'b1;
      tick;
      ale = 1'b0;
      n_checks++; if (data_valid !== 1'b1 || rmudata !== 8'h5A || port_id !== 1'b0)
        $display("FAIL stall_hold[%0d]: got v=%b d=%h p=%b want v=1 d=5a p=0", i, data_valid, rmudata, port_id);
      else n_pass++;
      n_checks++; if (ovr !== (i == 2)) $display("FAIL stall_ovr[%0d]: got %b want %b", i, ovr, (i == 2)); else n_pass++;
    end
    retire;
    tick;
    n_checks++; if (busy !== 1'b0 || data_valid !== 1'b0)
      $display("FAIL stall_no_new_frame: got busy=%b v=%b want 0 0", busy, data_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic early;
    logic ovr_seen;
    drive_frame(1'b1, 8'hA5, 1'b1, 1'b1, early);
    ovr_seen = ovr;
    data_ready = 1'b1; ale = 1'b1; ps1 = 1'b0;
    tick;
    data_ready = 1'b0; ale = 1'b0;
    ovr_seen |= ovr;
    n_checks++; if (data_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_retire: got v=%b busy=%b want 0 1", data_valid, busy); else n_pass++;
    for (int k = 0; k < 9; k++) begin
      rmuadd = (k < 8) ? 1'((8'h3C >> (7 - k)) & 8'h01) : 1'b1;
      tick;
      ovr_seen |= ovr;
      if (k < 8) begin
        n_checks++; if (data_valid !== 1'b0) $display("FAIL b2b_early[%0d]: got %b want 0", k, data_valid); else n_pass++;
      end
    end
    n_checks++; if (data_valid !== 1'b1 || rmudata !== 8'h3C || port_id !== 1'b0 || par_err !== 1'b0)
      $display("FAIL b2b_frame: got v=%b d=%h p=%b pe=%b want 1 3c 0 0", data_valid, rmudata, port_id, par_err);
    else n_pass++;
    n_checks++; if (ovr_seen !== 1'b0) $display("FAIL b2b_ovr: got %b want 0", ovr_seen); else n_pass++;
    retire;
  endtask

  task automatic test_reset_mid;
    logic early;
    logic v_seen;
    ale = 1'b1; ps1 = 1'b1;
    tick;
    ale = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rmuadd = 1'b1;
      tick;
    end
    reset = 1'b1; ale = 1'b1; data_ready = 1'b1;
    tick;
    reset = 1'b0; ale = 1'b0; data_ready = 1'b0;
    n_checks++; if ({rmudata, data_valid, port_id, par_err, ovr, busy} !== 13'h0)
      $display("FAIL rmid_outputs: got d=%h v=%b p=%b pe=%b o=%b b=%b want all 0",
               rmudata, data_valid, port_id, par_err, ovr, busy);
    else n_pass++;
    v_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      rmuadd = 1'($urandom_range(0, 1));
      tick;
      v_seen |= data_valid | busy;
    end
    n_checks++; if (v_seen !== 1'b0) $display("FAIL rmid_discard: got %b want 0", v_seen); else n_pass++;
    drive_frame(1'b0, 8'hFF, 1'b1, 1'b1, early);
    n_checks++; if (data_valid !== 1'b1 || rmudata !== 8'hFF || par_err !== 1'b0)
      $display("FAIL rmid_ff: got v=%b d=%h pe=%b want 1 ff 0", data_valid, rmudata, par_err);
    else n_pass++;
    retire;
  endtask

  task automatic test_random;
    logic [7:0] d, exp_d;
    logic       p, pb;
    int         glitch, stall, ovr_bad;
    for (int f = 0; f < 16; f++) begin
      d = 8'($urandom); p = 1'($urandom); pb = 1'($urandom);
      glitch = $urandom_range(0, 12);
      stall = $urandom_range(0, 3);
      ovr_bad = 0;
      exp_q.push_back(d);
      ale = 1'b1; ps1 = p;
      tick;
      ale = 1'b0;
      for (int k = 0; k < 9; k++) begin
        rmuadd = (k < 8) ? d[7-k] : pb;
        ale = (k == glitch);
        ps1 = 1'($urandom);
        tick;
        ale = 1'b0;
        if (ovr !== (k == glitch)) ovr_bad++;
      end
      exp_d = exp_q.pop_front();
      n_checks++; if (ovr_bad != 0) $display("FAIL rand_ovr[%0d]: got %0d bad cycles want 0", f, ovr_bad); else n_pass++;
      n_checks++; if (data_valid !== 1'b1 || rmudata !== exp_d || port_id !== p || par_err !== model_par_err(exp_d, pb))
        $display("FAIL rand_frame[%0d]: got v=%b d=%h p=%b pe=%b want 1 %h %b %b", f,
                 data_valid, rmudata, port_id, par_err, exp_d, p, model_par_err(exp_d, pb));
      else n_pass++;
      for (int s = 0; s < stall; s++) tick;
      retire;
      n_checks++; if (data_valid !== 1'b0 || rmudata !== exp_d)
        $display("FAIL rand_retire[%0d]: got v=%b d=%h want 0 %h", f, data_valid, rmudata, exp_d);
      else n_pass++;
    end
  endtask

  task automatic test_no_parity;
    logic early;
    logic [7:0] d;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive_frame(1'b1, 8'h01, 1'b0, 1'b0, early);
    n_checks++; if (early !== 1'b0) $display("FAIL np_early_valid: got %b want 0", early); else n_pass++;
    n_checks++; if (np_valid !== 1'b1 || np_rmudata !== 8'h01 || np_par_err !== 1'b0 || np_port_id !== 1'b1)
      $display("FAIL np_01: got v=%b d=%h pe=%b p=%b want 1 01 0 1", np_valid, np_rmudata, np_par_err, np_port_id);
    else n_pass++;
    retire;
    for (int f = 0; f < 4; f++) begin
      d = 8'($urandom);
      drive_frame(1'b0, d, 1'b0, 1'b0, early);
      n_checks++; if (np_valid !== 1'b1 || np_rmudata !== d || np_par_err !== 1'b0)
        $display("FAIL np_rand[%0d]: got v=%b d=%h pe=%b want 1 %h 0", f, np_valid, np_rmudata, np_par_err, d);
      else n_pass++;
      retire;
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5(1'b1);
    test_frame_a5(1'b0);
    test_hold_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_no_parity();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
